// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: counts ticks and lines from hs/vs edges,
// measures line/frame size, locks on stable timing and gates the active pixels.
module vga_sync_decoder #(
  parameter int   H_TOTAL     = 800,
  parameter int   V_TOTAL     = 525,
  parameter int   H_ACT_START = 144,
  parameter int   V_ACT_START = 35,
  parameter int   H_ACT       = 640,
  parameter int   V_ACT       = 480,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic       CLK,
  input  logic       clrn,
  input  logic       pix_en,
  input  logic       hs,
  input  logic       vs,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [8:0] row_addr,
  output logic [9:0] col_addr,
  output logic [11:0] pix,
  output logic       px_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       err_sticky
);

  localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0] H_AS    = 10'(H_ACT_START);
  localparam logic [9:0] V_AS    = 10'(V_ACT_START);
  localparam logic [9:0] H_AE    = 10'(H_ACT_START + H_ACT - 1);
  localparam logic [9:0] V_AE    = 10'(V_ACT_START + V_ACT - 1);
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQ, LOCKED} state_t;

  state_t state_q, state_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        vs_pend_q, vs_pend_d;
  logic [9:0]  line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic        bad_frame_q, bad_frame_d;
  logic        err_q, err_d, locked_q, locked_d;
  logic [8:0]  row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic [11:0] pix_q, pix_d;
  logic        px_valid_q, px_valid_d, frame_start_q, frame_start_d;

  logic hs_edge, vs_edge, valign, active, line_bad, frame_bad;
  logic [9:0] meas_len, meas_lines;

  assign hs_edge    = pix_en && (hs == SYNC_POL) && (hs_prev_q != SYNC_POL);
  assign vs_edge    = pix_en && (vs == SYNC_POL) && (vs_prev_q != SYNC_POL);
  assign valign     = hs_edge && (vs_pend_q || vs_edge);
  assign meas_len   = hcnt_q + 10'd1;
  assign meas_lines = vcnt_q + 10'd1;
  assign line_bad   = hs_edge && (meas_len != H_TOT);
  assign frame_bad  = valign && (meas_lines != V_TOT);

  // Tick/line counters; the tick index of an edge tick is 0, so downstream
  // logic looks at the _d values to describe the tick being sampled.
  always_comb begin
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    vs_pend_d     = vs_pend_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      hs_prev_d = hs;
      vs_prev_d = vs;
      if (hs_edge) begin
        line_len_d = meas_len;
        hcnt_d     = 10'd0;
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_d = hcnt_q + 10'd1;
      end
      if (valign) begin
        frame_lines_d = meas_lines;
        vcnt_d        = 10'd0;
        vs_pend_d     = 1'b0;
        frame_start_d = 1'b1;
      end else begin
        if (hs_edge && vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
        if (vs_edge) vs_pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    bad_frame_d = bad_frame_q;
    err_d       = err_q;
    if (pix_en) begin
      case (state_q)
        SEARCH: if (valign) begin
          state_d     = ACQ;
          good_cnt_d  = 8'd0;
          bad_frame_d = 1'b0;
        end
        ACQ: begin
          if (valign) begin
            bad_frame_d = 1'b0;
            if (bad_frame_q || line_bad || frame_bad) begin
              good_cnt_d = 8'd0;
            end else if (good_cnt_q + 8'd1 == LOCK_N) begin
              good_cnt_d = 8'd0;
              state_d    = LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + 8'd1;
            end
          end else if (line_bad) begin
            good_cnt_d  = 8'd0;
            bad_frame_d = 1'b1;
          end
        end
        LOCKED: if (line_bad || frame_bad || hcnt_d == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  assign active = (hcnt_d >= H_AS) && (hcnt_d <= H_AE) &&
                  (vcnt_d >= V_AS) && (vcnt_d <= V_AE);

  // Addresses hold their last active value through blanking; pix is blanked.
  always_comb begin
    locked_d   = (state_d == LOCKED);
    row_d      = row_q;
    col_d      = col_q;
    pix_d      = pix_q;
    px_valid_d = px_valid_q;
    if (pix_en) begin
      px_valid_d = locked_d && active;
      if (active) begin
        row_d = 9'(vcnt_d - V_AS);
        col_d = hcnt_d - H_AS;
        pix_d = {r_in, g_in, b_in};
      end else begin
        pix_d = 12'd0;
      end
    end
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) state_q <= SEARCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      hs_prev_q     <= ~SYNC_POL;
      vs_prev_q     <= ~SYNC_POL;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      vs_pend_q     <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      good_cnt_q    <= '0;
      bad_frame_q   <= 1'b0;
      err_q         <= 1'b0;
      locked_q      <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      pix_q         <= '0;
      px_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      vs_pend_q     <= vs_pend_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      good_cnt_q    <= good_cnt_d;
      bad_frame_q   <= bad_frame_d;
      err_q         <= err_d;
      locked_q      <= locked_d;
      row_q         <= row_d;
      col_q         <= col_d;
      pix_q         <= pix_d;
      px_valid_q    <= px_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row_addr    = row_q;
  assign col_addr    = col_q;
  assign pix         = pix_q;
  assign px_valid    = px_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err_sticky  = err_q;

endmodule
